// File: rtl/spi_slave_responder.sv
// spi_slave_responder: full-duplex SPI mode-0 slave running in the system
// clock domain. The master's sclk, cs and mosi are oversampled through
// synchronizer chains. Each frame shifts a WIDTH-bit word in from mosi and
// shifts the preloaded response (or IDLE_WORD) out on miso.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds a sticky o_frame_err
// flag for short and over-length frames.
module spi_slave_responder #(
    parameter int                WIDTH     = 12,
    parameter bit                LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0]  IDLE_WORD = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sclk,
    input  logic             i_cs,
    input  logic             i_mosi,
    output logic             o_miso,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_load,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic             o_frame_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [2:0]         r_sclk_sync;
    logic [2:0]         r_cs_sync;
    logic [1:0]         r_mosi_sync;

    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_miso;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;

    logic               w_sclk_rise;
    logic               w_sclk_fall;
    logic               w_cs_fall;
    logic               w_cs_rise;
    logic               w_mosi;
    logic               w_start;
    logic               w_last_bit;
    logic               w_short;
    logic [WIDTH-1:0]   w_frame_word;
    logic               w_first_bit;
    logic [WIDTH-1:0]   w_rx_next;
    logic [WIDTH-1:0]   w_tx_shifted;
    logic               w_next_tx_bit;

    // Two-flop synchronizers, plus a third stage on sclk and cs for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[1:0], i_cs};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    // mosi passes through the same depth as sclk[1], so it is aligned with the detected rise.
    assign w_mosi      = r_mosi_sync[1];

    assign w_start     = (r_state == ST_IDLE) && w_cs_fall;
    // The final sclk rise wins over a cs rise seen in the same cycle.
    assign w_last_bit  = (r_state == ST_ACTIVE) && w_sclk_rise &&
                         (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_short     = (r_state == ST_ACTIVE) && w_cs_rise && !w_last_bit;

    assign w_frame_word  = r_hold_full ? r_hold : IDLE_WORD;
    assign w_first_bit   = LSB_FIRST ? w_frame_word[0] : w_frame_word[WIDTH-1];
    assign w_rx_next     = LSB_FIRST ? {w_mosi, r_rx_shift[WIDTH-1:1]}
                                     : {r_rx_shift[WIDTH-2:0], w_mosi};
    assign w_tx_shifted  = LSB_FIRST ? (r_tx_shift >> 1) : (r_tx_shift << 1);
    assign w_next_tx_bit = LSB_FIRST ? r_tx_shift[1] : r_tx_shift[WIDTH-2];

    // Frame state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; WAIT leaves on cs level so a cs rise coinciding with the last bit is not lost.
    // NOTE: the default assignment first keeps this purely combinational (no inferred latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) w_next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_last_bit)     w_next_state = ST_WAIT;
                else if (w_cs_rise) w_next_state = ST_IDLE;
            end
            ST_WAIT: begin
                if (r_cs_sync[1]) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Response holding register: loads only when empty, emptied when a frame starts.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_start) r_hold_full <= 1'b0;
            // A load in the start cycle only lands when the register was already empty,
            // so it is kept for the following frame.
            if (i_tx_load && !r_hold_full) begin
                r_hold      <= i_tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    // Shift datapath: tx/rx shifters, bit counter, miso and the received-word output.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_miso     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_tx_shift <= w_frame_word;
                        r_bit_cnt  <= '0;
                        r_miso     <= w_first_bit;
                    end
                end
                ST_ACTIVE: begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_next;
                        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                    end
                    if (w_last_bit) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                    end else if (w_cs_rise) begin
                        r_miso <= 1'b0;
                    end else if (w_sclk_fall && (r_bit_cnt < CNT_W'(WIDTH))) begin
                        r_tx_shift <= w_tx_shifted;
                        r_miso     <= w_next_tx_bit;
                    end
                end
                ST_WAIT: begin
                    if (r_cs_sync[1]) r_miso <= 1'b0;
                end
                default: r_miso <= 1'b0;
            endcase
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic r_frame_err;

    // Sticky frame error: short frame or sclk rise after completion; cleared by the next good frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_frame_err <= 1'b0;
        end else if (w_last_bit) begin
            r_frame_err <= 1'b0;
        end else if (w_short || ((r_state == ST_WAIT) && w_sclk_rise)) begin
            r_frame_err <= 1'b1;
        end
    end

    assign o_frame_err = r_frame_err;
`endif

    assign o_miso     = r_miso;
    assign o_tx_ready = ~r_hold_full;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_busy     = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed testbench for spi_slave_responder (WIDTH=12, LSB first, IDLE_WORD=0).
// The bench acts as a mode-0 SPI master with a 200 ns sclk period on a 20 ns clk.
module tb_spi_slave_responder;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sclk    = 1'b0;
    logic        cs      = 1'b1;
    logic        mosi    = 1'b0;
    logic        tx_load = 1'b0;
    logic [11:0] tx_data = 12'h000;
    logic        miso;
    logic        tx_ready;
    logic        rx_valid;
    logic        busy;
    logic [11:0] rx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int rx_pulses = 0;
    int rx_hi = 0;
    logic rx_valid_d = 1'b0;

    spi_slave_responder #(
        .WIDTH(12),
        .LSB_FIRST(1'b1),
        .IDLE_WORD(12'h000)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_sclk(sclk),
        .i_cs(cs),
        .i_mosi(mosi),
        .o_miso(miso),
        .i_tx_data(tx_data),
        .i_tx_load(tx_load),
        .o_tx_ready(tx_ready),
        .o_rx_data(rx_data),
        .o_rx_valid(rx_valid),
        .o_busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .o_frame_err(frame_err)
`endif
    );

    always #10 clk = ~clk;

    // Count rx_valid pulses and high cycles, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_hi++;
            if (rx_valid_d !== 1'b1) rx_pulses++;
        end
        rx_valid_d = rx_valid;
    end

    task automatic load_tx(input logic [11:0] w);
        @(negedge clk);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Drop cs; optionally pulse tx_load in the cycle the slave detects the cs fall.
    task automatic cs_fall(input bit collide, input logic [11:0] cword);
        @(negedge clk);
        cs = 1'b0;
        if (collide) begin
            repeat (2) @(negedge clk);
            tx_data = cword;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic shift_bit(input logic b, output logic m);
        mosi = b;
        repeat (5) @(negedge clk);
        sclk = 1'b1;
        m = miso;
        repeat (5) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic cs_rise();
        repeat (5) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic frame(input logic [11:0] mo, input int nbits, input bit collide,
                         input logic [11:0] cword, output logic [11:0] mi);
        logic m;
        mi = 12'h000;
        cs_fall(collide, cword);
        for (int i = 0; i < nbits; i++) begin
            shift_bit((i < 12) ? mo[i] : 1'b0, m);
            if (i < 12) mi[i] = m;
        end
        cs_rise();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cs    = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", miso); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        n_cmp++; if (rx_data !== 12'h000) begin n_bad++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [11:0] mi;
        logic        m;
        int          p0, h0;
        p0 = rx_pulses;
        h0 = rx_hi;
        mi = 12'h000;
        load_tx(12'hA5C);
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_after_load: got %b want 0", tx_ready); end
        cs_fall(1'b0, 12'h000);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_after_cs: got %b want 1", tx_ready); end
        for (int i = 0; i < 12; i++) begin
            shift_bit(12'h3C7 >> i, m);
            mi[i] = m;
        end
        cs_rise();
        n_cmp++; if (mi !== 12'hA5C) begin n_bad++; $display("FAIL single_miso: got %h want a5c", mi); end
        n_cmp++; if (rx_data !== 12'h3C7) begin n_bad++; $display("FAIL single_rx_data: got %h want 3c7", rx_data); end
        n_cmp++; if (rx_pulses - p0 !== 1) begin n_bad++; $display("FAIL single_pulses: got %0d want 1", rx_pulses - p0); end
        n_cmp++; if (rx_hi - h0 !== 1) begin n_bad++; $display("FAIL single_pulse_width: got %0d want 1", rx_hi - h0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] tx_w [10] = '{12'h123, 12'hFED, 12'h800, 12'h001, 12'h5A5,
                                   12'hA5A, 12'hFFF, 12'h3E8, 12'h7C1, 12'h0F0};
        logic [11:0] rx_w [10] = '{12'h9B4, 12'h00F, 12'hC81, 12'h777, 12'h246,
                                   12'hE19, 12'h000, 12'hFFF, 12'h135, 12'h6D2};
        logic [11:0] mi;
        int          p0;
        frame(12'h0F0, 12, 1'b0, 12'h000, mi);
        n_cmp++; if (mi !== 12'h000) begin n_bad++; $display("FAIL nopreload_miso: got %h want 000", mi); end
        n_cmp++; if (rx_data !== 12'h0F0) begin n_bad++; $display("FAIL nopreload_rx: got %h want 0f0", rx_data); end
        p0 = rx_pulses;
        for (int k = 0; k < 10; k++) begin
            load_tx(tx_w[k]);
            frame(rx_w[k], 12, 1'b0, 12'h000, mi);
            n_cmp++; if (mi !== tx_w[k]) begin n_bad++; $display("FAIL b2b_miso[%0d]: got %h want %h", k, mi, tx_w[k]); end
            n_cmp++; if (rx_data !== rx_w[k]) begin n_bad++; $display("FAIL b2b_rx[%0d]: got %h want %h", k, rx_data, rx_w[k]); end
        end
        n_cmp++; if (rx_pulses - p0 !== 10) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 10", rx_pulses - p0); end
    endtask

    task automatic test_load_collision();
        logic [11:0] mi;
        load_tx(12'h5A1);
        load_tx(12'h111);
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL coll_ready_full: got %b want 0", tx_ready); end
        frame(12'h246, 12, 1'b0, 12'h000, mi);
        n_cmp++; if (mi !== 12'h5A1) begin n_bad++; $display("FAIL coll_ignored_load: got %h want 5a1", mi); end
        frame(12'h8E3, 12, 1'b1, 12'h9D4, mi);
        n_cmp++; if (mi !== 12'h000) begin n_bad++; $display("FAIL coll_same_cycle_miso: got %h want 000", mi); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL coll_word_kept: got %b want 0", tx_ready); end
        frame(12'h135, 12, 1'b0, 12'h000, mi);
        n_cmp++; if (mi !== 12'h9D4) begin n_bad++; $display("FAIL coll_next_frame: got %h want 9d4", mi); end
        n_cmp++; if (rx_data !== 12'h135) begin n_bad++; $display("FAIL coll_rx: got %h want 135", rx_data); end
    endtask

    task automatic test_short_frame();
        logic [11:0] mi;
        int          p0;
        p0 = rx_pulses;
        frame(12'hFFF, 7, 1'b0, 12'h000, mi);
        n_cmp++; if (rx_pulses !== p0) begin n_bad++; $display("FAIL short_no_valid: got %0d want %0d", rx_pulses, p0); end
        n_cmp++; if (rx_data !== 12'h135) begin n_bad++; $display("FAIL short_rx_kept: got %h want 135", rx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL short_busy: got %b want 0", busy); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short_frame_err: got %b want 1", frame_err); end
`endif
        frame(12'h6B2, 12, 1'b0, 12'h000, mi);
        n_cmp++; if (rx_data !== 12'h6B2) begin n_bad++; $display("FAIL short_next_rx: got %h want 6b2", rx_data); end
        n_cmp++; if (rx_pulses - p0 !== 1) begin n_bad++; $display("FAIL short_next_pulse: got %0d want 1", rx_pulses - p0); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short_err_cleared: got %b want 0", frame_err); end
`endif
        frame(12'h4D9, 13, 1'b0, 12'h000, mi);
        n_cmp++; if (rx_data !== 12'h4D9) begin n_bad++; $display("FAIL long_rx: got %h want 4d9", rx_data); end
        n_cmp++; if (rx_pulses - p0 !== 2) begin n_bad++; $display("FAIL long_pulse: got %0d want 2", rx_pulses - p0); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL long_frame_err: got %b want 1", frame_err); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] mi;
        logic        m;
        int          p0;
        p0 = rx_pulses;
        load_tx(12'hC3A);
        cs_fall(1'b0, 12'h000);
        for (int i = 0; i < 5; i++) shift_bit(1'b1, m);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", tx_ready); end
        cs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
        n_cmp++; if (rx_data !== 12'h000) begin n_bad++; $display("FAIL midrst_rx_data: got %h want 000", rx_data); end
        n_cmp++; if (rx_pulses !== p0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d want %0d", rx_pulses, p0); end
        frame(12'h2E8, 12, 1'b0, 12'h000, mi);
        n_cmp++; if (mi !== 12'h000) begin n_bad++; $display("FAIL midrst_hold_discarded: got %h want 000", mi); end
        n_cmp++; if (rx_data !== 12'h2E8) begin n_bad++; $display("FAIL midrst_next_rx: got %h want 2e8", rx_data); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_load_collision();
        test_short_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish within 5 ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- Full-duplex SPI slave in the system clock domain; the responding end of the team's 12-bit SPI master link.
- Oversamples the master's sclk, cs and mosi.
- Shifts a received 12-bit word in from mosi and shifts a preloaded 12-bit response out on miso in the same frame.
- Sits between the SPI pads and the local datapath, which loads responses and consumes received words.

Parameters:
- WIDTH, 12, frame length in bits. Also sets the width of rx_data and tx_data.
- LSB_FIRST, 1, 1 = bit 0 is transferred first on both mosi and miso; 0 = MSB first.
- IDLE_WORD, 12'h000, word sent on miso when no response is loaded at frame start.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- sclk  in  1  SPI clock from master, asynchronous to clk. Mode 0: idles low, sample on rise, shift on fall.
- cs  in  1  chip select from master, active-low, asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- tx_data  in  WIDTH  response word to send.
- tx_load  in  1  write strobe for tx_data; accepted only when tx_ready=1.
- tx_ready  out  1  1 = holding register empty.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  1 while a frame is in progress (state ACTIVE).

Behaviour:
- Reset (rst=0 at a clk edge):
  - Outputs: miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0.
  - Internal: holding register empty, bit counter 0, state IDLE.
  - Synchronizer flops: sclk/cs/mosi sync chains reset to 0/1/0.
- Reset mid-frame abandons the frame: no rx_valid, holding word discarded.
- Input sync: sclk, cs and mosi each pass through 2 flops.
  - A third flop on sclk and cs feeds edge detection.
  - Required ratio: sclk high and low phases each ≥4 clk periods.
- Holding register:
  - tx_load=1 with tx_ready=1 captures tx_data; tx_ready drops the next cycle.
  - tx_load with tx_ready=0 is ignored; holding contents unchanged.
- State IDLE:
  - miso=0, busy=0.
  - On detected cs fall: copy the holding word into the tx shifter, or IDLE_WORD if the holding register is empty.
  - Then clear the holding register (tx_ready=1 next cycle), clear the bit counter, drive miso with the first tx bit, and go to ACTIVE.
- cs fall and tx_load in the same cycle:
  - If the holding register was empty, the frame uses IDLE_WORD.
  - The loaded word stays in the holding register for the next frame.
- State ACTIVE, busy=1:
  - Detected sclk rise: shift the synchronized mosi into the rx shifter, increment the counter.
  - When the counter reaches WIDTH: rx_data ← assembled word and rx_valid=1 for exactly 1 cycle on the next clk. Then go to WAIT.
  - Detected sclk fall with counter < WIDTH: miso ← next tx bit.
  - Worst-case latency from the pad sclk rise of the last bit to rx_valid is 4 clk.
- Bit order: LSB_FIRST=1 means the first mosi bit lands in rx_data[0] and tx bit 0 goes out first.
- State WAIT: miso held, extra sclk edges ignored. Detected cs rise → IDLE.
- cs rise in ACTIVE before WIDTH bits (short frame):
  - Return to IDLE; no rx_valid; rx_data unchanged; received bits discarded.
  - The tx word is consumed, not restored.
- cs rise and the final sclk rise detected in the same cycle: the final rise takes precedence and the word completes (rx_valid pulses).
- Extra sclk edges while cs is high: ignored.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit), sticky.
  - Set on a short frame, and on any sclk rise detected in WAIT (over-length frame).
  - Cleared only by reset or by the next complete frame's rx_valid.
- Not defined: port absent; short and over-length frames handled silently as in Behaviour.

Test Plan:
- Reset: rst=0 for 5 clk with cs=1 → miso=0, rx_valid=0, tx_ready=1, rx_data=0, busy=0.
- Single frame, clk 20 ns, sclk period 200 ns, LSB first:
  - Load tx_data=12'hA5C, then the master sends 12'h3C7.
  - miso bits = 0,0,1,1,1,0,1,0,0,1,0,1.
  - One rx_valid pulse; rx_data=12'h3C7; tx_ready=1 after cs fall.
- No preload: frame with the holding register empty → miso carries 12'h000. Then 10 back-to-back frames with random words, each preloaded between frames → every rx_data and every miso word matches.
- Load collision:
  - tx_load of 12'h111 when tx_ready=0 → ignored; the next frame sends the earlier word.
  - tx_load in the same cycle as the cs fall with the holding register empty → that frame sends 12'h000, the next frame sends the loaded word.
- Short frame: cs rises after 7 bits → no rx_valid, rx_data keeps its previous value, frame_err=1 (macro on); the next full frame clears frame_err.
- Reset mid-frame after 5 bits → IDLE, busy=0, tx_ready=1; a following full frame completes correctly.
